// File: rtl/piso_serializer.sv
`default_nettype none
// =============================================================================
// piso_serializer: valid/ready word in, MSB-first serial out with divided strobe.
// Optional: `define SER_PARITY_EN appends one even-parity bit per frame.
// Rev 1.0
// =============================================================================
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_data,
  output logic             ser_shift_en,
  output logic             busy,
  output logic             frame_done
);

`ifdef SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int BCW = $clog2(WIDTH + 1);
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(NBITS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [DCW-1:0]   div_cnt;
  logic [BCW-1:0]   bit_cnt;
  logic             accept;
  logic             last_strobe;

`ifdef SER_PARITY_EN
  localparam logic [BCW-1:0] PAR_SLOT = BCW'(WIDTH);
  logic parity;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^load_data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_ready   = 1'b0;
    busy         = 1'b0;
    ser_data     = 1'b0;
    ser_shift_en = 1'b0;
    accept       = 1'b0;
    last_strobe  = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy         = 1'b1;
        ser_data     = sreg[WIDTH-1];
`ifdef SER_PARITY_EN
        if (bit_cnt == PAR_SLOT) begin
          ser_data = parity;
        end
`endif
        ser_shift_en = (div_cnt == DIV_LAST);
        if (ser_shift_en && (bit_cnt == BIT_LAST)) begin
          last_strobe = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt is cleared on the final strobe so it never wraps, even with parity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sreg       <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_strobe;
      if (accept) begin
        sreg    <= load_data;
        div_cnt <= '0;
        bit_cnt <= '0;
      end else if (busy) begin
        if (ser_shift_en) begin
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          div_cnt <= '0;
          bit_cnt <= last_strobe ? '0 : bit_cnt + BCW'(1);
        end else begin
          div_cnt <= div_cnt + DCW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter stage that sits directly upstream of the 4-bit serial-in shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the word MSB-first on ser_data, with a one-cycle ser_shift_en strobe per bit. These two outputs drive the downstream register's data_in and shift_en.
- A programmable clock divider sets the bit period, so the downstream stage can be paced slower than clk.

Parameters:
- WIDTH, 4, word width in bits (>=2).
- DIV, 1, clk cycles per serial bit (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  upstream word valid.
- load_data  input  WIDTH  parallel word to transmit.
- load_ready  output  1  block can accept a word (high only in IDLE).
- ser_data  output  1  current serial bit, MSB first; connects to downstream data_in.
- ser_shift_en  output  1  one-cycle strobe: downstream samples ser_data on this edge.
- busy  output  1  frame in progress (state SHIFT).
- frame_done  output  1  one-cycle pulse after the last bit strobe.

Behaviour:
- Reset: clock is clk; reset reset_n is asynchronous, active-low.
  - Asynchronous assertion forces state=IDLE and clears the shift register, div_cnt and bit_cnt.
  - Outputs during and after reset: ser_data=0, ser_shift_en=0, busy=0, frame_done=0, load_ready=1 (IDLE).
  - Reset mid-frame aborts the frame: no frame_done and no further strobes.
- State machine: IDLE, SHIFT.
- IDLE:
  - load_ready=1, ser_data=0, ser_shift_en=0.
  - On a clk edge with load_valid=1: capture load_data into sreg, clear div_cnt and bit_cnt, go to SHIFT.
- SHIFT:
  - load_ready=0, busy=1, ser_data=sreg[WIDTH-1].
  - div_cnt counts 0..DIV-1.
  - ser_shift_en=1 combinationally when div_cnt==DIV-1, otherwise 0.
  - On the strobe edge: sreg shifts left, filling 0 at the LSB; bit_cnt increments; div_cnt returns to 0.
  - On the strobe edge where bit_cnt==WIDTH-1: go to IDLE and register frame_done=1 for the next cycle.
- Latency and timing:
  - First strobe occurs DIV cycles after the accept edge.
  - SHIFT lasts exactly WIDTH*DIV cycles.
  - Each ser_data bit is stable for the full DIV-cycle bit period, including the strobe cycle.
  - With DIV=1, ser_shift_en is high every SHIFT cycle.
- Back-to-back frames:
  - frame_done and load_ready are high in the same cycle.
  - A word presented then is accepted, so the gap between frames is exactly one IDLE cycle.
- Handshake:
  - load_valid while busy is ignored; load_data is not captured.
  - load_data only needs to be stable on the accept edge.
- Counters:
  - bit_cnt width is clog2(WIDTH+1) (enough for WIDTH+1 with the optional parity bit).
  - div_cnt width is max(1, clog2(DIV)).
  - Neither counter wraps inside a frame.
- Downstream result: after the final strobe, the downstream register holds load_data in its original bit order.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - Parity is computed on accept as ^load_data and held in a register.
  - After the WIDTH data bits, one extra bit period drives ser_data = parity (even parity: total ones including the parity bit is even), with one extra strobe.
  - Frame length becomes (WIDTH+1)*DIV cycles; frame_done follows the parity strobe.
- Undefined: no parity logic; frames are exactly WIDTH bits.

Test Plan:
- WIDTH=4, DIV=1, load 4'b1011 -> ser_data=1,0,1,1 on 4 consecutive ser_shift_en cycles; frame_done pulses in cycle 5; downstream register reads 4'b1011.
- DIV=3, load 4'b0110 -> strobes on cycles 3,6,9,12 after accept; ser_data holds each bit for 3 cycles; busy high for exactly 12 cycles.
- Back-to-back: load_valid held high with 4'hA then 4'h5 -> serial stream 1,0,1,0 then 0,1,0,1; exactly one load_ready cycle (coincident with frame_done) between frames.
- Mid-frame load: load 4'h9, then assert load_valid with 4'h6 during SHIFT -> 4'h6 ignored, stream 1,0,0,1, no second frame unless re-presented in IDLE.
- Reset: assert reset_n=0 after the 2nd strobe of 4'hF -> ser_shift_en, busy and ser_data go to 0 immediately; no frame_done; load_ready=1; a fresh load after release transmits correctly.
- SER_PARITY_EN defined, load 4'b1011 -> 5 strobes: 1,0,1,1 then parity bit 1; frame_done after the 5th strobe.
